// File: rtl/fpu_add_arbiter.sv
// Two-requester round-robin arbiter in front of a fixed-latency FP add/sub datapath.
// Issues one operation per cycle, tags each issue with its requester id and routes
// the returned result back to that requester.  A drain handshake stops new grants
// and reports when nothing is left in flight.
// Optional feature: define FPU_ARB_TAG_CHECK_EN to add the sticky O_Tag_Err output.
module fpu_add_arbiter #(
    parameter int PRECISION    = 32,
    parameter int PIPE_LATENCY = 4
) (
    input  logic                 I_Clk,
    input  logic                 I_nReset,
    input  logic                 I_Req_Valid_0,
    input  logic                 I_Req_Valid_1,
    output logic                 O_Req_Ready_0,
    output logic                 O_Req_Ready_1,
    input  logic [PRECISION-1:0] I_Op1_0,
    input  logic [PRECISION-1:0] I_Op2_0,
    input  logic [PRECISION-1:0] I_Op1_1,
    input  logic [PRECISION-1:0] I_Op2_1,
    input  logic                 I_Sub_0,
    input  logic                 I_Sub_1,
    output logic                 O_Issue_Valid,
    output logic [PRECISION-1:0] O_Issue_Op1,
    output logic [PRECISION-1:0] O_Issue_Op2,
    output logic                 O_Issue_Sub,
    input  logic                 I_Res_Valid,
    input  logic [PRECISION-1:0] I_Res_Data,
    output logic                 O_Res_Valid_0,
    output logic                 O_Res_Valid_1,
    output logic [PRECISION-1:0] O_Res_Data,
    input  logic                 I_Drain,
    output logic                 O_Drained
`ifdef FPU_ARB_TAG_CHECK_EN
    ,
    output logic                 O_Tag_Err
`endif
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DRAINED = 2'd2
    } state_t;

    state_t state, state_nxt;

    // last_id = requester granted most recently; reset to 1 so requester 0 wins first
    logic last_id;
    logic issue_id;
    logic grant_open;
    logic xfer_0, xfer_1, xfer;

    // Tag pipe: entry i holds the issue from i+1 cycles after O_Issue_Valid
    logic [PIPE_LATENCY-1:0] tag_vld;
    logic [PIPE_LATENCY-1:0] tag_id;
    logic head_vld, head_id;
    logic route;

    logic [3:0] inflight;
    logic       drain_empty;

    // Grants only while running and not being asked to drain this very cycle
    assign grant_open = (state == ST_RUN) && !I_Drain;

    // Round-robin grant: on contention the requester not granted last wins
    always_comb begin
        O_Req_Ready_0 = 1'b0;
        O_Req_Ready_1 = 1'b0;
        if (grant_open) begin
            if (I_Req_Valid_0 && (!I_Req_Valid_1 || last_id))
                O_Req_Ready_0 = 1'b1;
            else if (I_Req_Valid_1)
                O_Req_Ready_1 = 1'b1;
        end
    end

    assign xfer_0 = I_Req_Valid_0 && O_Req_Ready_0;
    assign xfer_1 = I_Req_Valid_1 && O_Req_Ready_1;
    assign xfer   = xfer_0 || xfer_1;

    // Registered issue stage; operands hold when nothing is launched
    always_ff @(posedge I_Clk) begin
        if (!I_nReset) begin
            O_Issue_Valid <= 1'b0;
            O_Issue_Op1   <= '0;
            O_Issue_Op2   <= '0;
            O_Issue_Sub   <= 1'b0;
            issue_id      <= 1'b0;
            last_id       <= 1'b1;
        end else begin
            O_Issue_Valid <= xfer;
            if (xfer) begin
                last_id     <= xfer_1;
                issue_id    <= xfer_1;
                O_Issue_Op1 <= xfer_1 ? I_Op1_1 : I_Op1_0;
                O_Issue_Op2 <= xfer_1 ? I_Op2_1 : I_Op2_0;
                O_Issue_Sub <= xfer_1 ? I_Sub_1 : I_Sub_0;
            end
        end
    end

    // Tag shift register follows each issue down the datapath latency
    always_ff @(posedge I_Clk) begin
        if (!I_nReset) begin
            tag_vld <= '0;
            tag_id  <= '0;
        end else begin
            tag_vld[0] <= O_Issue_Valid;
            tag_id[0]  <= issue_id;
            for (int i = 1; i < PIPE_LATENCY; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
        end
    end

    assign head_vld = tag_vld[PIPE_LATENCY-1];
    assign head_id  = tag_id[PIPE_LATENCY-1];
    // A result with no matching tag (e.g. one launched before a reset) is dropped
    assign route    = I_Res_Valid && head_vld;

    // Result return, one cycle after the datapath presents it
    always_ff @(posedge I_Clk) begin
        if (!I_nReset) begin
            O_Res_Valid_0 <= 1'b0;
            O_Res_Valid_1 <= 1'b0;
            O_Res_Data    <= '0;
        end else begin
            O_Res_Valid_0 <= route && !head_id;
            O_Res_Valid_1 <= route && head_id;
            if (route)
                O_Res_Data <= I_Res_Data;
        end
    end

    // Operations between launch and routed result
    always_ff @(posedge I_Clk) begin
        if (!I_nReset) begin
            inflight <= 4'd0;
        end else begin
            case ({O_Issue_Valid, route})
                2'b10:   inflight <= inflight + 4'd1;
                2'b01:   inflight <= inflight - 4'd1;
                default: inflight <= inflight;
            endcase
        end
    end

    // Empty: nothing counted, nothing about to launch, nothing being routed now
    assign drain_empty = (inflight == 4'd0) && !O_Issue_Valid && !route;

    // State register
    always_ff @(posedge I_Clk) begin
        if (!I_nReset)
            state <= ST_RUN;
        else
            state <= state_nxt;
    end

    // Drain sequencing; dropping I_Drain always returns to RUN
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:     if (I_Drain) state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (!I_Drain)
                    state_nxt = ST_RUN;
                else if (drain_empty)
                    state_nxt = ST_DRAINED;
            end
            ST_DRAINED: if (!I_Drain) state_nxt = ST_RUN;
            default:    state_nxt = ST_RUN;
        endcase
    end

    assign O_Drained = (state == ST_DRAINED);

`ifdef FPU_ARB_TAG_CHECK_EN
    // Sticky flag: datapath result presence disagrees with the expected tag
    always_ff @(posedge I_Clk) begin
        if (!I_nReset)
            O_Tag_Err <= 1'b0;
        else if (I_Res_Valid != head_vld)
            O_Tag_Err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Randomized self-checking bench for fpu_add_arbiter.  The reference keeps a
// next-winner pointer, a queue of results due from the datapath and the expected
// hold values of every registered output; the datapath itself is modelled here.
module tb_fpu_add_arbiter;
    localparam int L   = 4;
    localparam int BIG = 1 << 30;

    logic        I_Clk = 1'b0;
    logic        I_nReset;
    logic        I_Req_Valid_0, I_Req_Valid_1;
    logic        O_Req_Ready_0, O_Req_Ready_1;
    logic [31:0] I_Op1_0, I_Op2_0, I_Op1_1, I_Op2_1;
    logic        I_Sub_0, I_Sub_1;
    logic        O_Issue_Valid;
    logic [31:0] O_Issue_Op1, O_Issue_Op2;
    logic        O_Issue_Sub;
    logic        I_Res_Valid;
    logic [31:0] I_Res_Data;
    logic        O_Res_Valid_0, O_Res_Valid_1;
    logic [31:0] O_Res_Data;
    logic        I_Drain;
    logic        O_Drained;
`ifdef FPU_ARB_TAG_CHECK_EN
    logic        O_Tag_Err;
`endif

    fpu_add_arbiter #(.PRECISION(32), .PIPE_LATENCY(L)) dut (
        .I_Clk(I_Clk), .I_nReset(I_nReset),
        .I_Req_Valid_0(I_Req_Valid_0), .I_Req_Valid_1(I_Req_Valid_1),
        .O_Req_Ready_0(O_Req_Ready_0), .O_Req_Ready_1(O_Req_Ready_1),
        .I_Op1_0(I_Op1_0), .I_Op2_0(I_Op2_0), .I_Op1_1(I_Op1_1), .I_Op2_1(I_Op2_1),
        .I_Sub_0(I_Sub_0), .I_Sub_1(I_Sub_1),
        .O_Issue_Valid(O_Issue_Valid), .O_Issue_Op1(O_Issue_Op1),
        .O_Issue_Op2(O_Issue_Op2), .O_Issue_Sub(O_Issue_Sub),
        .I_Res_Valid(I_Res_Valid), .I_Res_Data(I_Res_Data),
        .O_Res_Valid_0(O_Res_Valid_0), .O_Res_Valid_1(O_Res_Valid_1),
        .O_Res_Data(O_Res_Data),
        .I_Drain(I_Drain), .O_Drained(O_Drained)
`ifdef FPU_ARB_TAG_CHECK_EN
        , .O_Tag_Err(O_Tag_Err)
`endif
    );

    always #5 I_Clk = ~I_Clk;

    int n_cmp = 0, n_err = 0;
    int cyc = 0;

    // stimulus for the next cycle
    logic        d_rst_n, d_v0, d_v1, d_sub0, d_sub1, d_drain;
    logic [31:0] d_op1_0, d_op2_0, d_op1_1, d_op2_1;

    // reference state
    int          ptr = 0;             // requester that wins the next contention
    int          rq_due[$];           // cycle the datapath returns each result
    int          rq_id[$];            // destination requester, -1 once discarded
    logic        exp_iss_v = 0, exp_sub = 0;
    logic [31:0] exp_op1 = 0, exp_op2 = 0, exp_rdata = 0;
    logic        exp_rv0 = 0, exp_rv1 = 0, exp_tag_err = 0;
    logic        exp_open = 1;        // grants allowed by drain state
    int          drained_at = BIG, undrain_at = BIG;
    int          starve0 = 0, starve1 = 0, n_xfer = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        logic rv, e0, e1, x0, x1;
        logic [31:0] rd;
        int rid;
        @(posedge I_Clk);
        #1;
        cyc++;
        I_nReset = d_rst_n;
        I_Req_Valid_0 = d_v0; I_Req_Valid_1 = d_v1;
        I_Op1_0 = d_op1_0; I_Op2_0 = d_op2_0; I_Sub_0 = d_sub0;
        I_Op1_1 = d_op1_1; I_Op2_1 = d_op2_1; I_Sub_1 = d_sub1;
        I_Drain = d_drain;
        rv = 1'b0; rid = -1; rd = $urandom;
        if (rq_due.size() > 0 && rq_due[0] == cyc) begin
            rv = 1'b1;
            void'(rq_due.pop_front());
            rid = rq_id.pop_front();
        end
        I_Res_Valid = rv; I_Res_Data = rd;
        #1;
        // registered outputs expected for this cycle
        chk("iss_v", O_Issue_Valid, exp_iss_v);
        chk("iss_op1", O_Issue_Op1, exp_op1);
        chk("iss_op2", O_Issue_Op2, exp_op2);
        chk("iss_sub", O_Issue_Sub, exp_sub);
        chk("res_v0", O_Res_Valid_0, exp_rv0);
        chk("res_v1", O_Res_Valid_1, exp_rv1);
        chk("res_data", O_Res_Data, exp_rdata);
        chk("drained", O_Drained, (cyc >= drained_at) && (cyc < undrain_at));
`ifdef FPU_ARB_TAG_CHECK_EN
        chk("tag_err", O_Tag_Err, exp_tag_err);
`endif
        // combinational grant
        e0 = exp_open && !d_drain && d_v0 && (!d_v1 || ptr == 0);
        e1 = exp_open && !d_drain && d_v1 && (!d_v0 || ptr == 1);
        chk("rdy0", O_Req_Ready_0, e0);
        chk("rdy1", O_Req_Ready_1, e1);
        // no requester waits through more than one grant to the other
        if (d_v0 && O_Req_Ready_0) begin chk("fair0", starve0 <= 1, 1'b1); starve0 = 0; end
        else if (d_v0 && O_Req_Ready_1) starve0++;
        else if (!d_v0) starve0 = 0;
        if (d_v1 && O_Req_Ready_1) begin chk("fair1", starve1 <= 1, 1'b1); starve1 = 0; end
        else if (d_v1 && O_Req_Ready_0) starve1++;
        else if (!d_v1) starve1 = 0;
        // advance reference to next cycle
        x0 = e0; x1 = e1;
        exp_iss_v = x0 || x1;
        if (x0 || x1) begin
            n_xfer++;
            exp_op1 = x1 ? d_op1_1 : d_op1_0;
            exp_op2 = x1 ? d_op2_1 : d_op2_0;
            exp_sub = x1 ? d_sub1 : d_sub0;
            rq_due.push_back(cyc + 1 + L);
            rq_id.push_back(x1 ? 1 : 0);
            ptr = x1 ? 0 : 1;
        end
        exp_rv0 = (rid == 0);
        exp_rv1 = (rid == 1);
        if (rid >= 0) exp_rdata = rd;
        if (rv && rid < 0) exp_tag_err = 1'b1;
        if (!d_rst_n) begin
            exp_iss_v = 0; exp_op1 = 0; exp_op2 = 0; exp_sub = 0;
            exp_rv0 = 0; exp_rv1 = 0; exp_rdata = 0; exp_tag_err = 0;
            ptr = 0; starve0 = 0; starve1 = 0;
            foreach (rq_id[i]) rq_id[i] = -1;
        end
    endtask

    task automatic rand_ops();
        d_op1_0 = $urandom; d_op2_0 = $urandom; d_sub0 = 1'($urandom_range(0, 1));
        d_op1_1 = $urandom; d_op2_1 = $urandom; d_sub1 = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        d_v0 = 0; d_v1 = 0; d_drain = 0; d_rst_n = 0;
        step();
        d_rst_n = 1;
    endtask

    // From idle: raise drain, expect DRAINED two cycles later, then release
    task automatic drain_idle();
        d_v0 = 1; d_v1 = 1; rand_ops();
        exp_open = 0; drained_at = cyc + 3; d_drain = 1;
        repeat (4) step();
        undrain_at = cyc + 2; d_drain = 0;
        step();
        exp_open = 1; drained_at = BIG; undrain_at = BIG;
        d_v0 = 0; d_v1 = 0;
        repeat (L + 3) step();
    endtask

    initial begin
        I_nReset = 0; I_Req_Valid_0 = 0; I_Req_Valid_1 = 0; I_Drain = 0;
        I_Op1_0 = 0; I_Op2_0 = 0; I_Op1_1 = 0; I_Op2_1 = 0; I_Sub_0 = 0; I_Sub_1 = 0;
        I_Res_Valid = 0; I_Res_Data = 0;
        d_rst_n = 0; d_v0 = 0; d_v1 = 0; d_drain = 0; d_sub0 = 0; d_sub1 = 0;
        d_op1_0 = 0; d_op2_0 = 0; d_op1_1 = 0; d_op2_1 = 0;
        repeat (3) step();
        d_rst_n = 1;

        // single request 1.0 + 2.0
        d_v0 = 1; d_op1_0 = 32'h3F80_0000; d_op2_0 = 32'h4000_0000; d_sub0 = 0;
        step();
        d_v0 = 0;
        repeat (L + 4) step();

        // contention right after reset: 0,1,0,1
        do_reset();
        d_v0 = 1; d_v1 = 1;
        repeat (4) begin rand_ops(); step(); end
        d_v0 = 0; d_v1 = 0;
        repeat (L + 4) step();

        // drain with three operations in flight
        d_v0 = 1;
        repeat (3) begin rand_ops(); step(); end
        d_v1 = 1; d_drain = 1; exp_open = 0;
        drained_at = cyc + 3 + L;
        repeat (L + 5) step();
        undrain_at = cyc + 2; d_drain = 0;
        step();
        exp_open = 1; drained_at = BIG; undrain_at = BIG;
        repeat (3) begin rand_ops(); step(); end
        d_v0 = 0; d_v1 = 0;
        repeat (L + 4) step();

        // drain dropped before the pipe empties goes straight back to RUN
        d_v0 = 1; rand_ops(); step();
        d_drain = 1; step();
        d_drain = 0; exp_open = 0; step();
        exp_open = 1;
        repeat (2) begin rand_ops(); step(); end
        d_v0 = 0;
        repeat (L + 4) step();
        drain_idle();

        // random stream of at least 100 operations
        n_xfer = 0;
        for (int i = 0; i < 600 && n_xfer < 110; i++) begin
            d_v0 = ($urandom_range(0, 9) < 7);
            d_v1 = ($urandom_range(0, 9) < 7);
            rand_ops();
            step();
        end
        d_v0 = 0; d_v1 = 0;
        repeat (L + 4) step();
        drain_idle();

        // reset with two operations in flight; late results are dropped
        d_v0 = 1;
        repeat (2) begin rand_ops(); step(); end
        do_reset();
        repeat (L + 4) step();
        drain_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
